ar_addr_router: RTL and testbench

- Parametrised AXI read-address (AR) channel router for one master and NUM_SLAVES slaves.
- Broadcasts the AR payload to all slave ports and asserts ARVALID only on the slave whose configured address window matches ARADDR.
- Unmapped addresses are accepted by an internal default slave. It returns ARLEN+1 read beats with RRESP=DECERR on its own R channel, and the top-level R mux merges that channel.
- Sits between the master AR port and the per-slave AR ports in the AXI interconnect.

---
 rtl/ar_addr_router_if.sv | 60 ++++++
 rtl/ar_addr_router.sv | 108 ++++++++++
 tb/tb_ar_addr_router.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ar_addr_router_if.sv
// AR router bus bundle: master AR port, broadcast per-slave AR ports,
// default-slave R channel and the DECERR event counter.
interface ar_addr_router_if #(
  parameter int NUM_SLAVES = 2,
  parameter int ID_W       = 8,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 4,
  parameter int SIZE_W     = 3,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16
);
  logic [ID_W-1:0]              ARID_M;
  logic [ADDR_W-1:0]            ARADDR_M;
  logic [LEN_W-1:0]             ARLEN_M;
  logic [SIZE_W-1:0]            ARSIZE_M;
  logic [1:0]                   ARBURST_M;
  logic                         ARVALID_M;
  logic                         ARREADY_M;

  logic [NUM_SLAVES*ID_W-1:0]   ARID_S;
  logic [NUM_SLAVES*ADDR_W-1:0] ARADDR_S;
  logic [NUM_SLAVES*LEN_W-1:0]  ARLEN_S;
  logic [NUM_SLAVES*SIZE_W-1:0] ARSIZE_S;
  logic [NUM_SLAVES*2-1:0]      ARBURST_S;
  logic [NUM_SLAVES-1:0]        ARVALID_S;
  logic [NUM_SLAVES-1:0]        ARREADY_S;

  logic [ID_W-1:0]              RID_D;
  logic [DATA_W-1:0]            RDATA_D;
  logic [1:0]                   RRESP_D;
  logic                         RLAST_D;
  logic                         RVALID_D;
  logic                         RREADY_D;

  logic [CNT_W-1:0]             DECERR_CNT;

  modport master (
    output ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M,
    output ARBURST_M, ARVALID_M,
    input  ARREADY_M,
    input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S,
    input  ARBURST_S, ARVALID_S,
    output ARREADY_S,
    input  RID_D, RDATA_D, RRESP_D, RLAST_D, RVALID_D,
    output RREADY_D,
    input  DECERR_CNT
  );

  modport slave (
    input  ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M,
    input  ARBURST_M, ARVALID_M,
    output ARREADY_M,
    output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S,
    output ARBURST_S, ARVALID_S,
    input  ARREADY_S,
    output RID_D, RDATA_D, RRESP_D, RLAST_D, RVALID_D,
    input  RREADY_D,
    output DECERR_CNT
  );
endinterface

// File: rtl/ar_addr_router.sv
// AXI AR router: window decode, payload broadcast, DECERR default slave.
// Ports: ACLK, ARESETn (async low), bus (ar_addr_router_if.slave).
module ar_addr_router #(
  parameter int NUM_SLAVES = 2,
  parameter int ID_W       = 8,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 4,
  parameter int SIZE_W     = 3,
  parameter int DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE =
    {32'h0001_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_LIMIT =
    {32'h0001_FFFF, 32'h0000_FFFF},
  parameter int CNT_W      = 16
) (
  input logic              ACLK,
  input logic              ARESETn,
  ar_addr_router_if.slave  bus
);

  typedef enum logic {IDLE, RESP} state_t;

  logic [NUM_SLAVES-1:0] hit;
  logic [NUM_SLAVES-1:0] sel;
  logic                  miss;
  logic                  dflt_rdy;
  logic                  acc;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  err_q, err_d;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hit[i] = (bus.ARADDR_M >= SLV_BASE[i*ADDR_W +: ADDR_W]) &&
               (bus.ARADDR_M <= SLV_LIMIT[i*ADDR_W +: ADDR_W]);
    end
  end

  // Scan downward so the lowest matching index is written last.
  always_comb begin
    sel = '0;
    for (int i = NUM_SLAVES-1; i >= 0; i--) begin
      if (hit[i]) sel = NUM_SLAVES'(1) << i;
    end
  end

  assign miss     = ~|hit;
  assign dflt_rdy = (state_q == IDLE);
  assign acc      = bus.ARVALID_M & miss & dflt_rdy;

  assign bus.ARID_S    = {NUM_SLAVES{bus.ARID_M}};
  assign bus.ARADDR_S  = {NUM_SLAVES{bus.ARADDR_M}};
  assign bus.ARLEN_S   = {NUM_SLAVES{bus.ARLEN_M}};
  assign bus.ARSIZE_S  = {NUM_SLAVES{bus.ARSIZE_M}};
  assign bus.ARBURST_S = {NUM_SLAVES{bus.ARBURST_M}};
  assign bus.ARVALID_S = {NUM_SLAVES{bus.ARVALID_M}} & sel;
  assign bus.ARREADY_M = (|(sel & bus.ARREADY_S)) |
                         (miss & dflt_rdy);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      rid_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      rid_q   <= rid_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rid_d   = rid_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          state_d = RESP;
          rid_d   = bus.ARID_M;
          cnt_d   = bus.ARLEN_M;
          if (err_q != '1) err_d = err_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.RREADY_D) begin
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - LEN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.RVALID_D   = (state_q == RESP);
  assign bus.RID_D      = rid_q;
  assign bus.RDATA_D    = '0;
  assign bus.RRESP_D    = (state_q == RESP) ? 2'b11 : 2'b00;
  assign bus.RLAST_D    = (state_q == RESP) && (cnt_q == '0);
  assign bus.DECERR_CNT = err_q;

endmodule

// File: tb/tb_ar_addr_router.sv
// Bench for ar_addr_router: decode vector table plus R-beat scoreboard.
// Small counter width so DECERR saturation is reachable.
module tb_ar_addr_router;
  localparam int NS  = 2;
  localparam int CW  = 3;

  logic ACLK;
  logic ARESETn;

  ar_addr_router_if #(.NUM_SLAVES(NS), .CNT_W(CW)) bus ();

  ar_addr_router #(.NUM_SLAVES(NS), .CNT_W(CW)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus.slave)
  );

  typedef struct {
    logic        vld;
    logic [31:0] addr;
    logic [1:0]  rdy;
    logic [1:0]  e_avs;
    logic        e_arm;
  } vec_t;

  typedef struct {
    logic [7:0] id;
    logic       last;
  } beat_t;

  int checks   = 0;
  int failures = 0;
  beat_t sb[$];
  int exp_cnt = 0;

  logic [15:0] rr_pat;
  int rr_idx  = 0;
  int rr_len  = 0;
  int pend_len = 0;

  logic       stalled = 0;
  logic [7:0] prev_id;
  logic       prev_last;
  logic [1:0] prev_resp;

  function automatic void chk(string n, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endfunction

  initial begin
    ACLK = 0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.RREADY_D = 1'b1;
    forever begin
      @(posedge ACLK); #2;
      if (rr_idx < rr_len) begin
        bus.RREADY_D = rr_pat[rr_idx];
        rr_idx++;
      end else begin
        bus.RREADY_D = 1'b1;
      end
    end
  end

  always @(negedge ACLK) begin
    if (!ARESETn) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        chk("stall_valid", bus.RVALID_D, 1'b1);
        chk("stall_rid", bus.RID_D, prev_id);
        chk("stall_rlast", bus.RLAST_D, prev_last);
        chk("stall_rresp", bus.RRESP_D, prev_resp);
      end
      stalled = 0;
      if (bus.RVALID_D) begin
        if (bus.RREADY_D) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat rid=%0h", bus.RID_D);
          end else begin
            beat_t b;
            b = sb.pop_front();
            chk("rid", bus.RID_D, b.id);
            chk("rlast", bus.RLAST_D, b.last);
            chk("rresp", bus.RRESP_D, 2'b11);
            chk("rdata", bus.RDATA_D, 32'h0);
          end
        end else begin
          stalled   = 1;
          prev_id   = bus.RID_D;
          prev_last = bus.RLAST_D;
          prev_resp = bus.RRESP_D;
        end
      end
    end
  end

  task automatic do_miss(input logic [7:0] id, input logic [3:0] len,
                         input logic [31:0] addr);
    bit got;
    got = 0;
    bus.ARID_M    = id;
    bus.ARADDR_M  = addr;
    bus.ARLEN_M   = len;
    bus.ARSIZE_M  = 3'd2;
    bus.ARBURST_M = 2'b01;
    bus.ARVALID_M = 1'b1;
    for (int c = 0; c < 200; c++) begin
      #1;
      chk("arready_miss", bus.ARREADY_M, sb.size() == 0);
      got = bus.ARREADY_M;
      @(posedge ACLK); #1;
      if (got) break;
    end
    bus.ARVALID_M = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL miss_timeout got=0 exp=1");
    end else begin
      for (int k = 0; k <= int'(len); k++) begin
        beat_t b;
        b.id   = id;
        b.last = (k == int'(len));
        sb.push_back(b);
      end
      rr_idx = 0;
      rr_len = pend_len;
      if (exp_cnt < (1 << CW) - 1) exp_cnt++;
      chk("rvalid_first", bus.RVALID_D, 1'b1);
      chk("rid_first", bus.RID_D, id);
      chk("decerr_cnt", bus.DECERR_CNT, exp_cnt);
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int c = 0; c < 60; c++) begin
      if (sb.size() == 0 && !bus.RVALID_D) begin
        done = 1;
        break;
      end
      @(posedge ACLK); #1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout left=%0d exp=0", sb.size());
    end
  endtask

  vec_t vt[9];

  initial begin
    vt[0] = '{1'b1, 32'h0000_FFFF, 2'b01, 2'b01, 1'b1};
    vt[1] = '{1'b1, 32'h0000_FFFF, 2'b10, 2'b01, 1'b0};
    vt[2] = '{1'b1, 32'h0001_0000, 2'b10, 2'b10, 1'b1};
    vt[3] = '{1'b1, 32'h0001_0000, 2'b01, 2'b10, 1'b0};
    vt[4] = '{1'b1, 32'h0001_FFFF, 2'b11, 2'b10, 1'b1};
    vt[5] = '{1'b1, 32'h0002_0000, 2'b11, 2'b00, 1'b1};
    vt[6] = '{1'b1, 32'hFFFF_FFFF, 2'b00, 2'b00, 1'b1};
    vt[7] = '{1'b0, 32'h0000_0000, 2'b01, 2'b00, 1'b1};
    vt[8] = '{1'b1, 32'h0000_1000, 2'b00, 2'b01, 1'b0};

    ARESETn       = 1'b0;
    bus.ARID_M    = '0;
    bus.ARADDR_M  = '0;
    bus.ARLEN_M   = '0;
    bus.ARSIZE_M  = '0;
    bus.ARBURST_M = '0;
    bus.ARVALID_M = 1'b0;
    bus.ARREADY_S = '0;
    rr_pat        = '0;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_rvalid", bus.RVALID_D, 1'b0);
    chk("rst_rlast", bus.RLAST_D, 1'b0);
    chk("rst_cnt", bus.DECERR_CNT, 0);
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    chk("rst_rid", bus.RID_D, 8'h00);
    chk("rst_rresp", bus.RRESP_D, 2'b00);

    // combinational decode table
    for (int i = 0; i < 9; i++) begin
      logic [7:0] id;
      id = 8'($urandom_range(0, 255));
      bus.ARID_M    = id;
      bus.ARLEN_M   = 4'(i);
      bus.ARADDR_M  = vt[i].addr;
      bus.ARVALID_M = vt[i].vld;
      bus.ARREADY_S = vt[i].rdy;
      #1;
      chk($sformatf("avs_%0d", i), bus.ARVALID_S, vt[i].e_avs);
      chk($sformatf("arm_%0d", i), bus.ARREADY_M, vt[i].e_arm);
      chk($sformatf("arid_s_%0d", i), bus.ARID_S, {id, id});
      chk($sformatf("araddr_s_%0d", i), bus.ARADDR_S,
          {vt[i].addr, vt[i].addr});
      bus.ARVALID_M = 1'b0;
      @(posedge ACLK); #1;
    end
    chk("no_beat_after_table", bus.RVALID_D, 1'b0);
    chk("cnt_after_table", bus.DECERR_CNT, 0);

    // slave 1 back-pressure for 3 cycles
    bus.ARID_M    = 8'h3C;
    bus.ARLEN_M   = 4'd5;
    bus.ARADDR_M  = 32'h0001_0000;
    bus.ARVALID_M = 1'b1;
    bus.ARREADY_S = 2'b00;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_avs", bus.ARVALID_S, 2'b10);
      chk("bp_arm", bus.ARREADY_M, 1'b0);
      @(posedge ACLK); #1;
    end
    bus.ARREADY_S = 2'b10;
    #1;
    chk("bp_arm_go", bus.ARREADY_M, 1'b1);
    chk("bp_avs_go", bus.ARVALID_S, 2'b10);
    chk("bp_slot1_addr", bus.ARADDR_S[63:32], 32'h0001_0000);
    chk("bp_slot1_len", bus.ARLEN_S[7:4], 4'd5);
    chk("bp_slot1_id", bus.ARID_S[15:8], 8'h3C);
    @(posedge ACLK); #1;
    bus.ARVALID_M = 1'b0;
    bus.ARREADY_S = 2'b00;
    chk("bp_no_beat", bus.RVALID_D, 1'b0);

    // DECERR burst, RREADY held high: done in ARLEN+1 cycles
    pend_len = 0;
    do_miss(8'h5A, 4'd3, 32'h0002_0000);
    repeat (4) @(posedge ACLK);
    #1;
    chk("burst4_done", sb.size(), 0);
    chk("burst4_idle", bus.RVALID_D, 1'b0);

    // stalls, then a second miss held off until IDLE
    rr_pat   = 16'b0000_0000_0011_1001;
    pend_len = 6;
    do_miss(8'h5A, 4'd3, 32'h0002_0000);
    pend_len = 0;
    do_miss(8'hA5, 4'd0, 32'h8000_0000);
    wait_drain();

    // a hit handshakes while the DECERR burst is active
    do_miss(8'h11, 4'd7, 32'h0003_0000);
    bus.ARADDR_M  = 32'h0000_1000;
    bus.ARVALID_M = 1'b1;
    bus.ARREADY_S = 2'b01;
    #1;
    chk("hit_in_resp_avs", bus.ARVALID_S, 2'b01);
    chk("hit_in_resp_arm", bus.ARREADY_M, 1'b1);
    chk("hit_in_resp_rv", bus.RVALID_D, 1'b1);
    @(posedge ACLK); #1;
    bus.ARVALID_M = 1'b0;
    bus.ARREADY_S = 2'b00;
    chk("hit_in_resp_rv2", bus.RVALID_D, 1'b1);
    wait_drain();

    // reset during beat 2 of an 8-beat burst
    do_miss(8'h77, 4'd7, 32'h0004_0000);
    @(posedge ACLK); #1;
    ARESETn = 1'b0;
    #1;
    chk("mid_rst_rvalid", bus.RVALID_D, 1'b0);
    chk("mid_rst_rlast", bus.RLAST_D, 1'b0);
    chk("mid_rst_cnt", bus.DECERR_CNT, 0);
    sb.delete();
    exp_cnt = 0;
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    repeat (6) @(posedge ACLK);
    #1;
    chk("post_rst_quiet", bus.RVALID_D, 1'b0);

    // counter saturates, never wraps
    for (int k = 0; k < 9; k++) begin
      do_miss(8'(k), 4'd0, 32'hFFFF_FFFF);
    end
    wait_drain();
    chk("cnt_sat", bus.DECERR_CNT, 3'b111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
